// File: rtl/pe_ipad_ring.sv
// Input scratchpad for one PE row: a circular store of Depth words filled over
// a valid/ready handshake. Sliding windows are replayed to the MAC datapath,
// and stride words are popped after each window's final repeat so overlapping
// pixels are reused without being fetched again.
module pe_ipad_ring #(
  parameter int unsigned DWd    = 16,
  parameter int unsigned Depth  = 12,
  parameter int unsigned NWinWd = 8,
  parameter int unsigned RepWd  = 4,
  localparam int unsigned AWd   = $clog2(Depth),
  localparam int unsigned CWd   = $clog2(Depth + 1),
  localparam int unsigned TWd   = NWinWd + CWd
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic [CWd-1:0]    i_conf_win,
  input  logic [CWd-1:0]    i_conf_stride,
  input  logic [NWinWd-1:0] i_conf_nwin,
  input  logic [RepWd-1:0]  i_conf_rep,
  input  logic              i_ipix_valid,
  input  logic [DWd-1:0]    i_ipix_data,
  output logic              o_ipix_ready,
  output logic              o_pix_valid,
  input  logic              i_pix_ready,
  output logic [DWd-1:0]    o_pix_data,
  output logic              o_pix_zero,
  output logic              o_pix_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e r_state, w_state_d;
  logic   r_err, w_err_d;
  logic   w_start_ok;

  // Scratchpad storage with one zero flag per word
  logic [DWd-1:0] r_mem   [Depth];
  logic           r_zflag [Depth];

  // Pointers and counters
  logic [AWd-1:0]    r_wptr,    w_wptr_d;
  logic [AWd-1:0]    r_base,    w_base_d;
  logic [CWd-1:0]    r_count,   w_count_d;
  logic [CWd-1:0]    r_roff,    w_roff_d;
  logic [RepWd-1:0]  r_rep_cnt, w_rep_cnt_d;
  logic [NWinWd-1:0] r_win_cnt, w_win_cnt_d;
  logic [TWd-1:0]    r_in_cnt,  w_in_cnt_d;

  // Latched pass configuration (minus-one forms for terminal compares)
  logic [CWd-1:0]    r_win,     w_win_d;
  logic [CWd-1:0]    r_stride,  w_stride_d;
  logic [NWinWd-1:0] r_nwin_m1, w_nwin_m1_d;
  logic [RepWd-1:0]  r_rep_m1,  w_rep_m1_d;
  logic [TWd-1:0]    r_total,   w_total_d;

  logic              w_legal;
  logic [NWinWd-1:0] w_conf_nwin_m1;
  logic [TWd-1:0]    w_conf_total;
  logic              w_run;
  logic              w_ipix_ready;
  logic              w_pix_valid;
  logic              w_wr;
  logic              w_rd;
  logic [CWd-1:0]    w_win_m1;
  logic              w_win_end;
  logic              w_rep_end;
  logic              w_last_win;
  logic              w_pop;
  logic              w_final;
  logic [CWd-1:0]    w_pop_amt;
  logic [CWd:0]      w_idx_sum;
  logic [CWd:0]      w_idx_wrap;
  logic [AWd-1:0]    w_rd_idx;
  logic [CWd:0]      w_base_sum;
  logic [CWd:0]      w_base_wrap;
  logic [AWd-1:0]    w_wptr_inc;

  // Config legality and total input words needed for the pass
  always_comb begin
    w_legal = (i_conf_win != '0) && (i_conf_win <= CWd'(Depth)) &&
              (i_conf_stride != '0) && (i_conf_stride <= i_conf_win) &&
              (i_conf_nwin != '0) && (i_conf_rep != '0);
    w_conf_nwin_m1 = i_conf_nwin - NWinWd'(1);
    w_conf_total   = TWd'(i_conf_win) + TWd'(w_conf_nwin_m1) * TWd'(i_conf_stride);
  end

  // Handshakes, window/repeat terminal conditions and wrapped indices
  always_comb begin
    w_run        = (r_state == StRun);
    w_ipix_ready = w_run && !i_stall && (r_count < CWd'(Depth)) && (r_in_cnt < r_total);
    w_pix_valid  = w_run && !i_stall && (r_roff < r_count);
    w_wr         = w_ipix_ready && i_ipix_valid;
    w_rd         = w_pix_valid && i_pix_ready;

    w_win_m1   = r_win - CWd'(1);
    w_win_end  = (r_roff == w_win_m1);
    w_rep_end  = (r_rep_cnt == r_rep_m1);
    w_last_win = (r_win_cnt == r_nwin_m1);
    w_pop      = w_rd && w_win_end && w_rep_end;
    w_final    = w_pop && w_last_win;

    // The final window drains everything it covered; others drop only stride
    if (!w_pop)       w_pop_amt = '0;
    else if (w_final) w_pop_amt = r_win;
    else              w_pop_amt = r_stride;

    // base < Depth and roff < Depth, so one conditional subtract wraps
    w_idx_sum  = (CWd+1)'(r_base) + (CWd+1)'(r_roff);
    w_idx_wrap = (w_idx_sum >= (CWd+1)'(Depth)) ? w_idx_sum - (CWd+1)'(Depth) : w_idx_sum;
    w_rd_idx   = AWd'(w_idx_wrap);

    w_base_sum  = (CWd+1)'(r_base) + (CWd+1)'(r_stride);
    w_base_wrap = (w_base_sum >= (CWd+1)'(Depth)) ? w_base_sum - (CWd+1)'(Depth) : w_base_sum;

    w_wptr_inc = (r_wptr == AWd'(Depth - 1)) ? '0 : r_wptr + AWd'(1);
  end

  // FSM next state; stall freezes everything including start handling
  always_comb begin
    w_state_d  = r_state;
    w_err_d    = 1'b0;
    w_start_ok = 1'b0;
    if (!i_stall) begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            if (w_legal) begin
              w_state_d  = StRun;
              w_start_ok = 1'b1;
            end else begin
              w_err_d = 1'b1;
            end
          end
        end
        StRun:   if (w_final) w_state_d = StDone;
        StDone:  w_state_d = StIdle;
        default: w_state_d = StIdle;
      endcase
    end
  end

  // Pointer, counter and config next-state
  always_comb begin
    w_wptr_d    = r_wptr;
    w_base_d    = r_base;
    w_count_d   = r_count;
    w_roff_d    = r_roff;
    w_rep_cnt_d = r_rep_cnt;
    w_win_cnt_d = r_win_cnt;
    w_in_cnt_d  = r_in_cnt;
    w_win_d     = r_win;
    w_stride_d  = r_stride;
    w_nwin_m1_d = r_nwin_m1;
    w_rep_m1_d  = r_rep_m1;
    w_total_d   = r_total;
    if (w_start_ok) begin
      w_wptr_d    = '0;
      w_base_d    = '0;
      w_count_d   = '0;
      w_roff_d    = '0;
      w_rep_cnt_d = '0;
      w_win_cnt_d = '0;
      w_in_cnt_d  = '0;
      w_win_d     = i_conf_win;
      w_stride_d  = i_conf_stride;
      w_nwin_m1_d = w_conf_nwin_m1;
      w_rep_m1_d  = i_conf_rep - RepWd'(1);
      w_total_d   = w_conf_total;
    end else begin
      if (w_wr) begin
        w_wptr_d   = w_wptr_inc;
        w_in_cnt_d = r_in_cnt + TWd'(1);
      end
      if (w_rd) begin
        if (!w_win_end) begin
          w_roff_d = r_roff + CWd'(1);
        end else begin
          w_roff_d = '0;
          if (!w_rep_end) begin
            w_rep_cnt_d = r_rep_cnt + RepWd'(1);
          end else begin
            w_rep_cnt_d = '0;
            if (!w_last_win) begin
              w_base_d    = AWd'(w_base_wrap);
              w_win_cnt_d = r_win_cnt + NWinWd'(1);
            end
          end
        end
      end
      // Write and pop may coincide; net occupancy change is +wr - popped
      w_count_d = r_count + CWd'(w_wr) - w_pop_amt;
    end
  end

  // State and error pulse registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_err   <= w_err_d;
    end
  end

  // Pointer, counter and config registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr    <= '0;
      r_base    <= '0;
      r_count   <= '0;
      r_roff    <= '0;
      r_rep_cnt <= '0;
      r_win_cnt <= '0;
      r_in_cnt  <= '0;
      r_win     <= '0;
      r_stride  <= '0;
      r_nwin_m1 <= '0;
      r_rep_m1  <= '0;
      r_total   <= '0;
    end else begin
      r_wptr    <= w_wptr_d;
      r_base    <= w_base_d;
      r_count   <= w_count_d;
      r_roff    <= w_roff_d;
      r_rep_cnt <= w_rep_cnt_d;
      r_win_cnt <= w_win_cnt_d;
      r_in_cnt  <= w_in_cnt_d;
      r_win     <= w_win_d;
      r_stride  <= w_stride_d;
      r_nwin_m1 <= w_nwin_m1_d;
      r_rep_m1  <= w_rep_m1_d;
      r_total   <= w_total_d;
    end
  end

  // Scratchpad write port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_mem[i]   <= '0;
        r_zflag[i] <= 1'b0;
      end
    end else if (w_wr) begin
      r_mem[r_wptr]   <= i_ipix_data;
      r_zflag[r_wptr] <= (i_ipix_data == '0);
    end
  end

  // Outputs; read data is gated so stalled or idle cycles present zeros
  always_comb begin
    o_ipix_ready = w_ipix_ready;
    o_pix_valid  = w_pix_valid;
    o_pix_data   = w_pix_valid ? r_mem[w_rd_idx] : '0;
    o_pix_zero   = w_pix_valid && r_zflag[w_rd_idx];
    o_pix_last   = w_pix_valid && w_win_end && w_rep_end && w_last_win;
    o_busy       = w_run;
    o_done       = (r_state == StDone);
    o_err        = r_err;
  end

endmodule

// File: tb/tb_pe_ipad_ring.sv
// Bench for pe_ipad_ring: a reference model expands each pass into the list of
// pixels the window walk must produce; a monitor pops and compares on every
// read handshake while a driver and a consumer apply random handshake timing.
`timescale 1ns/1ps
module tb_pe_ipad_ring;
  localparam int unsigned DWd    = 16;
  localparam int unsigned Depth  = 12;
  localparam int unsigned NWinWd = 8;
  localparam int unsigned RepWd  = 4;
  localparam int unsigned CWd    = $clog2(Depth + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              i_start = 1'b0;
  logic              i_stall = 1'b0;
  logic [CWd-1:0]    i_conf_win = '0;
  logic [CWd-1:0]    i_conf_stride = '0;
  logic [NWinWd-1:0] i_conf_nwin = '0;
  logic [RepWd-1:0]  i_conf_rep = '0;
  logic              i_ipix_valid = 1'b0;
  logic [DWd-1:0]    i_ipix_data = '0;
  logic              i_pix_ready = 1'b0;
  logic              o_ipix_ready, o_pix_valid, o_pix_zero, o_pix_last;
  logic              o_busy, o_done, o_err;
  logic [DWd-1:0]    o_pix_data;

  pe_ipad_ring #(.DWd(DWd), .Depth(Depth), .NWinWd(NWinWd), .RepWd(RepWd)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stall(i_stall),
    .i_conf_win(i_conf_win), .i_conf_stride(i_conf_stride), .i_conf_nwin(i_conf_nwin),
    .i_conf_rep(i_conf_rep), .i_ipix_valid(i_ipix_valid), .i_ipix_data(i_ipix_data),
    .o_ipix_ready(o_ipix_ready), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
    .o_pix_data(o_pix_data), .o_pix_zero(o_pix_zero), .o_pix_last(o_pix_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DWd-1:0] data;
    logic           zero;
    logic           last;
  } exp_t;

  exp_t           exp_q[$];
  logic [DWd-1:0] in_q[$];
  int n_chk = 0, n_fail = 0;
  int in_idx = 0, n_in = 0, rd_hs_cnt = 0, done_cnt = 0;
  int vpct = 100, rpct = 100;
  bit drv_en = 0, mon_en = 0, hold_ready = 0, exp_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pix_valid"}, 32'(o_pix_valid), 0);
    chk({tag, "_ipix_ready"}, 32'(o_ipix_ready), 0);
    chk({tag, "_pix_data"}, 32'(o_pix_data), 0);
    chk({tag, "_pix_zero"}, 32'(o_pix_zero), 0);
    chk({tag, "_pix_last"}, 32'(o_pix_last), 0);
  endtask

  // Scoreboard monitor: compares every read handshake and the done pulse
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en && !rst) begin
        chk("done_timing", 32'(o_done), 32'(exp_done));
        exp_done = 0;
        if (o_done) done_cnt++;
        if (o_ipix_ready) chk("ipix_ready_cap", 32'(in_idx < n_in), 1);
        if (o_pix_valid && i_pix_ready) begin
          rd_hs_cnt++;
          if (exp_q.size() == 0) begin
            chk("scoreboard_underflow", 32'(exp_q.size()), 1);
          end else begin
            e = exp_q.pop_front();
            chk("pix_data", 32'(o_pix_data), 32'(e.data));
            chk("pix_zero", 32'(o_pix_zero), 32'(e.zero));
            chk("pix_last", 32'(o_pix_last), 32'(e.last));
            if (e.last) exp_done = 1;
          end
        end
      end
    end
  endtask

  // Input driver: offers in_q in order with random valid gaps
  task automatic driver();
    bit acc;
    forever begin
      @(negedge clk);
      acc = i_ipix_valid && o_ipix_ready && !rst;
      @(posedge clk);
      #2;
      if (acc) in_idx++;
      if (drv_en && in_idx < n_in) begin
        i_ipix_valid = ($urandom_range(0, 99) < vpct);
        i_ipix_data  = in_q[in_idx];
      end else begin
        i_ipix_valid = 1'b0;
        i_ipix_data  = '0;
      end
    end
  endtask

  task automatic consumer();
    forever begin
      @(posedge clk);
      #2;
      i_pix_ready = !hold_ready && ($urandom_range(0, 99) < rpct);
    end
  endtask

  // Reference model: window w, repeat r, offset k reads input w*stride+k
  task automatic start_pass(input int win, input int stride, input int nwin, input int rep,
                            input bit rand_data);
    int total;
    logic [DWd-1:0] v;
    exp_t e;
    total = win + (nwin - 1) * stride;
    if (rand_data) begin
      in_q.delete();
      for (int i = 0; i < total; i++) begin
        v = ($urandom_range(0, 3) == 0) ? '0 : DWd'($urandom_range(1, 65535));
        in_q.push_back(v);
      end
    end
    exp_q.delete();
    for (int w = 0; w < nwin; w++)
      for (int r = 0; r < rep; r++)
        for (int k = 0; k < win; k++) begin
          e.data = in_q[w * stride + k];
          e.zero = (in_q[w * stride + k] == '0);
          e.last = (w == nwin - 1) && (r == rep - 1) && (k == win - 1);
          exp_q.push_back(e);
        end
    n_in = total; in_idx = 0; rd_hs_cnt = 0; done_cnt = 0; exp_done = 0;
    drv_en = 1; mon_en = 1;
    @(posedge clk); #1;
    i_conf_win = CWd'(win); i_conf_stride = CWd'(stride);
    i_conf_nwin = NWinWd'(nwin); i_conf_rep = RepWd'(rep);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic wait_pass();
    int cyc = 0;
    while (done_cnt == 0 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("pass_completed", 32'(done_cnt), 1);
    @(negedge clk); #1;
    chk("busy_after_done", 32'(o_busy), 0);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    chk("inputs_consumed", 32'(in_idx), 32'(n_in));
    drv_en = 0; mon_en = 0;
  endtask

  task automatic wait_hs(input int n);
    int cyc = 0;
    while (rd_hs_cnt < n && cyc < 2000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("hs_wait", 32'(rd_hs_cnt >= n), 1);
  endtask

  task automatic try_bad(input int win, input int stride, input string tag);
    @(posedge clk); #1;
    i_conf_win = CWd'(win); i_conf_stride = CWd'(stride);
    i_conf_nwin = NWinWd'(2); i_conf_rep = RepWd'(1);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk({tag, "_err_pulse"}, 32'(o_err), 1);
    chk({tag, "_stay_idle"}, 32'(o_busy), 0);
    @(negedge clk);
    chk({tag, "_err_clear"}, 32'(o_err), 0);
    chk({tag, "_still_idle"}, 32'(o_busy), 0);
  endtask

  initial begin
    int cyc;
    int win, stride;
    fork
      monitor();
      driver();
      consumer();
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    chk_outputs_zero("reset");
    chk("reset_busy", 32'(o_busy), 0);
    chk("reset_done", 32'(o_done), 0);
    chk("reset_err", 32'(o_err), 0);
    rst = 1'b0;

    // Basic overlap: 1..6, win 3 stride 1, four windows
    in_q.delete();
    for (int i = 1; i <= 6; i++) in_q.push_back(DWd'(i));
    vpct = 100; rpct = 100;
    start_pass(3, 1, 4, 1, 0);
    wait_pass();

    // Non-overlapping windows with repeats, base wraps; mid-pass start ignored
    vpct = 100; rpct = 100;
    start_pass(4, 4, 5, 2, 1);
    repeat (8) @(posedge clk);
    #1;
    i_conf_win = CWd'(13); i_start = 1'b1;
    @(posedge clk); #1;
    i_conf_win = CWd'(2); i_conf_stride = CWd'(1);
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("midpass_start_no_err", 32'(o_err), 0);
    chk("midpass_still_busy", 32'(o_busy), 1);
    wait_pass();

    // Full scratchpad with consumer held off
    hold_ready = 1; vpct = 100; rpct = 100;
    start_pass(12, 1, 2, 1, 1);
    cyc = 0;
    while (in_idx < 12 && cyc < 200) begin
      @(negedge clk); #1;
      cyc++;
    end
    @(negedge clk); #1;
    chk("full_ipix_ready", 32'(o_ipix_ready), 0);
    chk("full_pix_valid", 32'(o_pix_valid), 1);
    hold_ready = 0;
    wait_hs(12);
    chk("ready_before_pop", 32'(o_ipix_ready), 0);
    @(negedge clk); #1;
    chk("ready_after_pop", 32'(o_ipix_ready), 1);
    wait_pass();

    // Zero flags and stall mid-window
    in_q.delete();
    in_q.push_back(DWd'(0)); in_q.push_back(DWd'(5)); in_q.push_back(DWd'(0));
    vpct = 100; rpct = 100;
    start_pass(3, 1, 1, 4, 0);
    wait_hs(4);
    @(posedge clk); #1;
    i_stall = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk_outputs_zero("stall");
    end
    @(posedge clk); #1;
    i_stall = 1'b0;
    wait_pass();

    // Config rejections
    try_bad(13, 1, "win13");
    try_bad(3, 0, "stride0");
    try_bad(2, 3, "stride_gt_win");

    // Reset mid-pass, then a clean pass
    vpct = 80; rpct = 80;
    start_pass(4, 2, 6, 2, 1);
    wait_hs(5);
    mon_en = 0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk_outputs_zero("midrst");
    chk("midrst_busy", 32'(o_busy), 0);
    chk("midrst_done", 32'(o_done), 0);
    drv_en = 0; in_idx = 0; exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_pass(5, 3, 3, 2, 1);
    wait_pass();

    // Random legal passes with random handshake timing
    for (int p = 0; p < 8; p++) begin
      win    = $urandom_range(1, Depth);
      stride = $urandom_range(1, win);
      vpct   = $urandom_range(40, 100);
      rpct   = $urandom_range(40, 100);
      start_pass(win, stride, $urandom_range(1, 6), $urandom_range(1, 3), 1);
      wait_pass();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
